// File: rtl/image_write_if.sv
// Signal bundle for image_write: config writes, result-stream handshake and
// the memory write port toward image_mem.
interface image_write_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
);
  logic [CFG_DWIDTH-1:0]         cfg_data;
  logic [CFG_AWIDTH-1:0]         cfg_addr;
  logic                          cfg_valid;
  logic                          next;
  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus;
  logic                          image_last;
  logic                          image_val;
  logic                          image_rdy;
  logic                          wr_val;
  logic [MEM_AWIDTH-1:0]         wr_addr;
  logic [GROUP_NB*IMG_WIDTH-1:0] wr_data;
  logic                          done;
  logic                          err_last;

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid, next,
    input  image_bus, image_last, image_val,
    output image_rdy, wr_val, wr_addr, wr_data, done, err_last
  );

  modport master (
    output cfg_data, cfg_addr, cfg_valid, next,
    output image_bus, image_last, image_val,
    input  image_rdy, wr_val, wr_addr, wr_data, done, err_last
  );
endinterface

// File: rtl/image_write.sv
// Writes a seg_w x seg_h x seg_d result stream into an HxWxD image buffer
// (depth fastest) at a depth offset and base address, one word per beat.
//
// state   | meaning
// RESET   | one idle cycle after reset or after a completed segment
// CONFIG  | waiting for next; cfg writes land in the shadow registers
// SETUP   | phase 0 latches working regs, phase 1 registers plane
// ACTIVE  | accepting beats, one memory write per accepted beat
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_SEG   = CFG_AWIDTH'(0),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_DEPTH = CFG_AWIDTH'(1),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_BUF   = CFG_AWIDTH'(2),
  parameter logic [CFG_AWIDTH-1:0] CFG_IW_BASE  = CFG_AWIDTH'(3)
) (
  input  logic         clk,
  input  logic         rst,
  image_write_if.slave bus_if
);
  localparam int DW = GROUP_NB * IMG_WIDTH;

  typedef enum logic [3:0] {
    S_RESET  = 4'b0001,
    S_CONFIG = 4'b0010,
    S_SETUP  = 4'b0100,
    S_ACTIVE = 4'b1000
  } state_t;

  state_t state_q, state_d;

  // shadow registers, written at any time, not reset
  logic [15:0] seg_w_sh_q, seg_h_sh_q, seg_d_sh_q, buf_d_sh_q, buf_w_sh_q, d_off_sh_q;
  logic [31:0] base_sh_q;

  logic [15:0] seg_w_max_q, seg_h_max_q, seg_d_max_q;
  logic [31:0] buf_w_q, buf_d_q, plane_q;
  logic [31:0] row_ptr_q, col_ptr_q;
  logic [15:0] d_cnt_q, w_cnt_q, h_cnt_q;
  logic        setup_ph_q;

  logic                  wr_val_q, done_q, err_last_q;
  logic [MEM_AWIDTH-1:0] wr_addr_q;
  logic [DW-1:0]         wr_data_q;

  logic accept, d_last, w_last, h_last, final_beat;

  assign accept     = bus_if.image_val & state_q[3];
  assign d_last     = (d_cnt_q == seg_d_max_q);
  assign w_last     = (w_cnt_q == seg_w_max_q);
  assign h_last     = (h_cnt_q == seg_h_max_q);
  assign final_beat = d_last & w_last & h_last;

  always_ff @(posedge clk) begin
    if (bus_if.cfg_valid) begin
      case (bus_if.cfg_addr)
        CFG_IW_SEG: begin
          seg_w_sh_q <= bus_if.cfg_data[31:16];
          seg_h_sh_q <= bus_if.cfg_data[15:0];
        end
        CFG_IW_DEPTH: begin
          seg_d_sh_q <= bus_if.cfg_data[31:16];
          buf_d_sh_q <= bus_if.cfg_data[15:0];
        end
        CFG_IW_BUF: begin
          buf_w_sh_q <= bus_if.cfg_data[31:16];
          d_off_sh_q <= bus_if.cfg_data[15:0];
        end
        CFG_IW_BASE: base_sh_q <= bus_if.cfg_data[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_CONFIG;
      S_CONFIG: if (bus_if.next) state_d = S_SETUP;
      S_SETUP:  if (setup_ph_q) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && final_beat) state_d = S_RESET;
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      setup_ph_q <= 1'b0;
      d_cnt_q    <= '0;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      wr_val_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_last_q <= 1'b0;
    end else begin
      wr_val_q   <= accept;
      done_q     <= accept & final_beat;
      wr_data_q  <= accept ? bus_if.image_bus : '0;
      setup_ph_q <= (state_q == S_SETUP) & ~setup_ph_q;

      if (state_q == S_SETUP && !setup_ph_q) begin
        seg_w_max_q <= seg_w_sh_q;
        seg_h_max_q <= seg_h_sh_q;
        seg_d_max_q <= seg_d_sh_q;
        buf_w_q     <= {16'd0, buf_w_sh_q} + 32'd1;
        buf_d_q     <= {16'd0, buf_d_sh_q} + 32'd1;
        row_ptr_q   <= base_sh_q + {16'd0, d_off_sh_q};
        col_ptr_q   <= base_sh_q + {16'd0, d_off_sh_q};
        d_cnt_q     <= '0;
        w_cnt_q     <= '0;
        h_cnt_q     <= '0;
        err_last_q  <= 1'b0;
      end

      // the only multiply, kept out of the per-beat path
      if (state_q == S_SETUP && setup_ph_q)
        plane_q <= buf_w_q * buf_d_q;

      if (accept) begin
        wr_addr_q <= col_ptr_q[MEM_AWIDTH-1:0] + MEM_AWIDTH'(d_cnt_q);
        if (bus_if.image_last != final_beat) err_last_q <= 1'b1;
        if (!d_last) begin
          d_cnt_q <= d_cnt_q + 16'd1;
        end else begin
          d_cnt_q <= '0;
          if (!w_last) begin
            w_cnt_q   <= w_cnt_q + 16'd1;
            col_ptr_q <= col_ptr_q + buf_d_q;
          end else begin
            w_cnt_q <= '0;
            if (!h_last) begin
              h_cnt_q   <= h_cnt_q + 16'd1;
              row_ptr_q <= row_ptr_q + plane_q;
              col_ptr_q <= row_ptr_q + plane_q;
            end else begin
              h_cnt_q <= '0;
            end
          end
        end
      end
    end
  end

  assign bus_if.image_rdy = state_q[3];
  assign bus_if.wr_val    = wr_val_q;
  assign bus_if.wr_addr   = wr_addr_q;
  assign bus_if.wr_data   = wr_data_q;
  assign bus_if.done      = done_q;
  assign bus_if.err_last  = err_last_q;
endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write: directed segments plus randomized
// segments compared cycle by cycle against a loop-based address model.
module tb_image_write;
  localparam int CFG_DWIDTH = 32;
  localparam int CFG_AWIDTH = 5;
  localparam int GROUP_NB   = 4;
  localparam int IMG_WIDTH  = 16;
  localparam int MEM_AWIDTH = 16;
  localparam logic [4:0] A_SEG = 5'd0, A_DEPTH = 5'd1, A_BUF = 5'd2, A_BASE = 5'd3;

  logic clk = 1'b0;
  logic rst;

  image_write_if #(.CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .GROUP_NB(GROUP_NB),
                   .IMG_WIDTH(IMG_WIDTH), .MEM_AWIDTH(MEM_AWIDTH)) bus_if ();

  image_write #(.CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .GROUP_NB(GROUP_NB),
                .IMG_WIDTH(IMG_WIDTH), .MEM_AWIDTH(MEM_AWIDTH),
                .CFG_IW_SEG(A_SEG), .CFG_IW_DEPTH(A_DEPTH), .CFG_IW_BUF(A_BUF),
                .CFG_IW_BASE(A_BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: shadow config, expected address list, expected outputs
  longint unsigned sh_sw, sh_sh, sh_sd, sh_bw, sh_bd, sh_doff, sh_base;
  int          exp_addr[$];
  int          total, beat;
  bit          m_rdy, m_cfgst, m_err;
  int          rcd, scd;
  bit          e_wval, e_done;
  logic [15:0] e_addr;
  logic [63:0] e_data;

  task automatic build_list();
    longint unsigned a;
    exp_addr.delete();
    for (longint unsigned h = 0; h < sh_sh; h++)
      for (longint unsigned w = 0; w < sh_sw; w++)
        for (longint unsigned d = 0; d < sh_sd; d++) begin
          a = sh_base + sh_doff + h * sh_bw * sh_bd + w * sh_bd + d;
          exp_addr.push_back(int'(a & 64'hFFFF));
        end
    total = exp_addr.size();
    beat  = 0;
  endtask

  // one clock: check outputs of the previous edge, drive inputs, model the coming edge
  task automatic step(input bit v, input logic [63:0] bus, input bit last, input bit nxt,
                      input bit r, input bit cv, input logic [4:0] ca, input logic [31:0] cd);
    bit acc;
    @(negedge clk);
    check_eq("image_rdy", bus_if.image_rdy, m_rdy);
    check_eq("wr_val", bus_if.wr_val, e_wval);
    check_eq("wr_data", bus_if.wr_data, e_data);
    if (e_wval) check_eq("wr_addr", bus_if.wr_addr, e_addr);
    check_eq("done", bus_if.done, e_done);
    check_eq("err_last", bus_if.err_last, m_err);
    if (bus_if.wr_val === 1'b1) n_wr++;

    rst               = r;
    bus_if.image_val  = v;
    bus_if.image_bus  = bus;
    bus_if.image_last = last;
    bus_if.next       = nxt;
    bus_if.cfg_valid  = cv;
    bus_if.cfg_addr   = ca;
    bus_if.cfg_data   = cd;

    if (cv) begin
      case (ca)
        A_SEG:   begin sh_sw = cd[31:16] + 1; sh_sh = cd[15:0] + 1; end
        A_DEPTH: begin sh_sd = cd[31:16] + 1; sh_bd = cd[15:0] + 1; end
        A_BUF:   begin sh_bw = cd[31:16] + 1; sh_doff = cd[15:0]; end
        A_BASE:  sh_base = cd;
        default: ;
      endcase
    end

    if (r) begin
      m_rdy = 0; m_cfgst = 0; m_err = 0; rcd = 1; scd = 0;
      e_wval = 0; e_done = 0; e_data = '0; e_addr = '0;
      exp_addr.delete(); total = 0; beat = 0;
    end else begin
      acc    = v && m_rdy;
      e_wval = acc;
      e_data = acc ? bus : '0;
      e_done = 0;
      if (acc) begin
        e_addr = 16'(exp_addr[beat]);
        e_done = (beat == total - 1);
        if (last != e_done) m_err = 1;
        beat++;
      end
      if (acc && e_done) begin
        m_rdy = 0; rcd = 1;
      end else if (rcd > 0) begin
        rcd--;
        if (rcd == 0) m_cfgst = 1;
      end else if (scd > 0) begin
        scd--;
        if (scd == 1) m_err = 0;
        if (scd == 0) m_rdy = 1;
      end else if (nxt && m_cfgst) begin
        build_list();
        scd = 2; m_cfgst = 0;
      end
    end
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic cfg_set(input int sw, input int sh, input int sd, input int bw,
                         input int bd, input int doff, input logic [31:0] base);
    step(0, '0, 0, 0, 0, 1, A_SEG,   {16'(sw - 1), 16'(sh - 1)});
    step(0, '0, 0, 0, 0, 1, A_DEPTH, {16'(sd - 1), 16'(bd - 1)});
    step(0, '0, 0, 0, 0, 1, A_BUF,   {16'(bw - 1), 16'(doff)});
    step(0, '0, 0, 0, 0, 1, A_BASE,  base);
  endtask

  // gap: 0 continuous, 1 alternate, 2 random; last_at<0 means the final beat
  task automatic run_seg(input int gap, input int last_at, input int rst_at,
                         input bit nxt_final, input int pre_val, input bit mid_cfg);
    int wr0, exp_wr, lpos;
    bit v, lst, nx, cfg_done, aborted;
    logic [63:0] bus;
    cfg_done = 0; aborted = 0;
    for (int i = 0; i < pre_val; i++) step(1, {$urandom, $urandom}, 0, 0, 0, 0, '0, '0);
    step(pre_val > 0, {$urandom, $urandom}, 0, 1, 0, 0, '0, '0);
    wr0    = n_wr;
    lpos   = (last_at < 0) ? total - 1 : last_at;
    exp_wr = (rst_at >= 0) ? rst_at : total;
    for (int c = 0; c < total * 4 + 20 && beat < total; c++) begin
      if (rst_at >= 0 && beat == rst_at) begin
        step(0, '0, 0, 0, 1, 0, '0, '0);
        aborted = 1;
        break;
      end
      case (gap)
        0:       v = 1;
        1:       v = (c % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus = {$urandom, $urandom};
      lst = v && (beat == lpos);
      nx  = nxt_final && v && m_rdy && (beat == total - 1);
      if (mid_cfg && !cfg_done && beat == 1) begin
        step(v, bus, lst, nx, 0, 1, A_BASE, $urandom);
        cfg_done = 1;
      end else begin
        step(v, bus, lst, nx, 0, 0, '0, '0);
      end
    end
    for (int i = 0; i < 6 && !m_cfgst; i++) idle();
    idle();
    check_eq("seg_writes", 64'(n_wr - wr0), 64'(exp_wr));
    if (!aborted) check_eq("seg_complete", 64'(m_cfgst), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw, sh, sd, bw, bd;
    rst = 1;
    bus_if.image_val = 0; bus_if.image_bus = '0; bus_if.image_last = 0; bus_if.next = 0;
    bus_if.cfg_valid = 0; bus_if.cfg_addr = '0; bus_if.cfg_data = '0;
    m_rdy = 0; m_cfgst = 0; m_err = 0; rcd = 1; scd = 0;
    e_wval = 0; e_done = 0; e_data = '0; e_addr = '0; total = 0; beat = 0;
    sh_sw = 1; sh_sh = 1; sh_sd = 1; sh_bw = 1; sh_bd = 1; sh_doff = 0; sh_base = 0;
    repeat (2) @(posedge clk);
    step(0, '0, 0, 0, 1, 0, '0, '0);
    step(0, '0, 0, 0, 1, 0, '0, '0);
    check_eq("rst_wr_addr", bus_if.wr_addr, 64'd0);
    idle();
    idle();

    cfg_set(2, 2, 2, 4, 4, 1, 32'd100);
    check_eq("list_first", 64'(exp_addr.size()), 64'd0);
    run_seg(0, -1, -1, 0, 0, 0);
    check_eq("tp1_addr_last", 64'(exp_addr[7]), 64'd122);
    run_seg(1, -1, -1, 0, 0, 0);
    run_seg(0, 2, -1, 0, 0, 0);
    run_seg(2, -1, -1, 0, 0, 0);

    cfg_set(1, 1, 4, 1, 4, 0, 32'h0000_FFFE);
    run_seg(0, -1, -1, 0, 0, 0);

    cfg_set(2, 2, 2, 4, 4, 1, 32'd100);
    run_seg(0, -1, 3, 0, 0, 0);
    run_seg(0, -1, -1, 0, 0, 0);
    run_seg(0, -1, -1, 0, 4, 0);
    run_seg(2, -1, -1, 1, 0, 1);
    run_seg(0, -1, -1, 0, 0, 0);

    for (int s = 0; s < 30; s++) begin
      sw = $urandom_range(1, 3); sh = $urandom_range(1, 3); sd = $urandom_range(1, 3);
      bw = sw + $urandom_range(0, 2); bd = sd + $urandom_range(0, 3);
      cfg_set(sw, sh, sd, bw, bd, $urandom_range(0, bd - sd), $urandom);
      run_seg($urandom_range(0, 2),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, sw * sh * sd - 1) : -1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, sw * sh * sd - 1) : -1,
              1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
